fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the five-stage RV32I core: owns the PC, drives the single-outstanding instruction-memory request, and owns the IF/ID pipeline register. It is the consumer of the hazard controller's outputs: it applies `PCWrite`, `IFID_RegWrite`, `InstrFlush` and `BranchCtrl` redirects. Variable memory latency is absorbed by a small FSM and reported upstream as `fetch_stall`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `BranchCtrl`  in  2  next-PC select: PC4=2'b00, PCIMM=2'b01, IMMRS1=2'b10; 2'b11 treated as PC4.
- `pc_imm_target`  in  32  branch/JAL target (PC+imm) from EX.
- `rs1_imm_target`  in  32  JALR target (rs1+imm) from EX; bit 0 forced to 0 when used.
- `PCWrite`  in  1  1 = PC may advance; 0 = hold PC (load-use).
- `IFID_RegWrite`  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- `InstrFlush`  in  1  1 = load NOP into IF/ID.
- `im_req`  out  1  instruction-memory read request, one-cycle pulse.
- `im_addr`  out  32  request address, valid while `im_req`=1.
- `im_valid`  in  1  read data valid; at least 1 cycle after `im_req`.
- `im_rdata`  in  32  instruction word, valid with `im_valid`.
- `fetch_stall`  out  1  1 = no instruction available this cycle; rest of pipeline must freeze.
- `IFID_pc`  out  32  PC of instruction in IF/ID.
- `IFID_instr`  out  32  instruction in IF/ID.
- `IFID_valid`  out  1  0 for bubbles/flushed slots.

## Operation
- States: IDLE (only after reset), WAIT (one request outstanding), HOLD (fetched word buffered during load-use).
- `advance` = (WAIT and `im_valid`) or HOLD. `fetch_stall` = not `advance`. Hazard inputs are sampled only in `advance` cycles; the pipeline holds them steady otherwise.
- Fetched word F/PC P: `im_rdata` in WAIT, hold buffer in HOLD.
- next_pc: `BranchCtrl`=PCIMM -> `pc_imm_target`; IMMRS1 -> {`rs1_imm_target`[31:1],1'b0}; else P+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- IDLE: `im_req`=1, `im_addr`=pc; -> WAIT.
- WAIT, no `im_valid`: nothing changes, `im_req`=0.
- Advance with redirect (`BranchCtrl`≠PC4): F discarded; IF/ID <= NOP 32'h0000_0013, valid 0; pc <= target; `im_req`=1 at target same cycle; -> WAIT. Redirect outranks all other inputs.
- Advance, `PCWrite`=0 and `IFID_RegWrite`=0: IF/ID unchanged; F/P stored in hold buffer (WAIT) or kept (HOLD); no request; -> HOLD.
- Advance, normal: IF/ID <= {P, F, valid 1} (NOP/valid 0 if `InstrFlush`); pc <= P+4; `im_req`=1 at P+4; -> WAIT.
- `im_valid` in IDLE/HOLD is ignored (protocol violation, no state change).

## Timing
- Reset (`rst_n`=0 at edge): pc=`RESET_PC`, state IDLE, `IFID_pc`=0, `IFID_instr`=32'h0000_0013, `IFID_valid`=0, hold buffer cleared; `im_req`=0, `fetch_stall`=1 while `rst_n`=0. First request in the first cycle with `rst_n`=1.
- `im_req`/`im_addr` combinational from state and current-cycle inputs; at most one outstanding.
- Zero-wait memory (`im_valid` the cycle after `im_req`): one instruction into IF/ID per cycle after 2-cycle startup.
- Redirect penalty: redirect cycle + memory latency; branch flush of ID-stage instruction handled by hazard controller via `CtrlSignalFlush` (not an input here).
- Reset mid-request: response of the aborted request is ignored because state is IDLE.

## Structure
- Shared package `core_pkg`: `BranchCtrl` encodings (PC4/PCIMM/IMMRS1), `NOP_INSTR`=32'h0000_0013, `fetch_state_e` {IDLE, WAIT, HOLD}.
- Natural sub-module: `if_id_reg` (IF/ID register with load enable and flush-to-NOP); PC, FSM and hold buffer stay in `fetch_unit`.

## Test plan
- Reset then zero-wait memory returning addr-as-data: IF/ID shows pc 0,4,8 on consecutive cycles, `IFID_valid`=1, `fetch_stall` only during startup.
- 3-cycle memory latency: `fetch_stall`=1 for 3 cycles per fetch, IF/ID and pc unchanged during stall, no second `im_req`.
- Load-use: `PCWrite`=0,`IFID_RegWrite`=0 on fetch of pc 0x10 -> IF/ID held, state HOLD, no `im_req`; next cycle normal -> IF/ID gets pc 0x10 with buffered word, request 0x14.
- `BranchCtrl`=PCIMM, `pc_imm_target`=0x100 at pc 0x20 -> IF/ID NOP valid 0, `im_addr`=0x100 same cycle; IMMRS1 with 0x203 -> request 0x202.
- Redirect while in HOLD -> buffered word discarded, request at target; `rst_n`=0 during outstanding request then late `im_valid` -> ignored, first post-reset `im_addr`=`RESET_PC`.
- pc 32'hFFFF_FFFC normal advance -> next request 0x0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I core front end: next-PC select codes,
// canonical NOP, and the fetch FSM state type.
package core_pkg;

  localparam logic [1:0]  BR_PC4    = 2'b00;
  localparam logic [1:0]  BR_PCIMM  = 2'b01;
  localparam logic [1:0]  BR_IMMRS1 = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads {pc, instr, valid} on enable, or a NOP
// bubble when flush accompanies the load.
module if_id_reg
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pcIn,
  input  logic [31:0] instrIn,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid
);

  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic        valid_r;

  // Pipeline register; a flushed slot keeps its pc but carries a NOP marked invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r    <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else if (load) begin
      pc_r <= pcIn;
      if (flush) begin
        instr_r <= NOP_INSTR;
        valid_r <= 1'b0;
      end else begin
        instr_r <= instrIn;
        valid_r <= 1'b1;
      end
    end else begin
      pc_r    <= pc_r;
      instr_r <= instr_r;
      valid_r <= valid_r;
    end
  end

  assign IFID_pc    = pc_r;
  assign IFID_instr = instr_r;
  assign IFID_valid = valid_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, load-use
// hold buffer, and the IF/ID register.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  BranchCtrl,
  input  logic [31:0] pc_imm_target,
  input  logic [31:0] rs1_imm_target,
  input  logic        PCWrite,
  input  logic        IFID_RegWrite,
  input  logic        InstrFlush,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_valid,
  input  logic [31:0] im_rdata,
  output logic        fetch_stall,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid
);

  fetch_state_e state_r;
  fetch_state_e nextState_s;
  logic [31:0]  pc_r;
  logic [31:0]  nextPc_s;
  logic [31:0]  holdPc_r;
  logic [31:0]  holdInstr_r;
  logic         holdLoad_s;

  logic         advance_s;
  logic         redirect_s;
  logic [31:0]  fetchPc_s;
  logic [31:0]  fetchInstr_s;
  logic [31:0]  seqPc_s;
  logic [31:0]  target_s;
  logic         reqRaw_s;
  logic         ifidLoad_s;
  logic         ifidFlush_s;

  // Fetched word/PC source and the candidate next-PC values.
  always_comb begin
    advance_s  = ((state_r == WAIT) && im_valid) || (state_r == HOLD);
    redirect_s = (BranchCtrl == BR_PCIMM) || (BranchCtrl == BR_IMMRS1);
    if (state_r == HOLD) begin
      fetchPc_s    = holdPc_r;
      fetchInstr_s = holdInstr_r;
    end else begin
      fetchPc_s    = pc_r;
      fetchInstr_s = im_rdata;
    end
    seqPc_s = fetchPc_s + 32'd4;
    if (BranchCtrl == BR_IMMRS1) begin
      target_s = {rs1_imm_target[31:1], 1'b0};
    end else begin
      target_s = pc_imm_target;
    end
  end

  // Next-state, request and IF/ID control; redirect outranks the load-use hold.
  always_comb begin
    nextState_s = state_r;
    nextPc_s    = pc_r;
    reqRaw_s    = 1'b0;
    im_addr     = pc_r;
    ifidLoad_s  = 1'b0;
    ifidFlush_s = 1'b0;
    holdLoad_s  = 1'b0;
    case (state_r)
      IDLE: begin
        reqRaw_s    = 1'b1;
        im_addr     = pc_r;
        nextState_s = WAIT;
      end
      WAIT, HOLD: begin
        if (!advance_s) begin
          nextState_s = state_r;
        end else if (redirect_s) begin
          ifidLoad_s  = 1'b1;
          ifidFlush_s = 1'b1;
          nextPc_s    = target_s;
          reqRaw_s    = 1'b1;
          im_addr     = target_s;
          nextState_s = WAIT;
        end else if (!PCWrite && !IFID_RegWrite) begin
          holdLoad_s  = (state_r == WAIT);
          nextState_s = HOLD;
        end else begin
          ifidLoad_s  = 1'b1;
          ifidFlush_s = InstrFlush;
          nextPc_s    = seqPc_s;
          reqRaw_s    = 1'b1;
          im_addr     = seqPc_s;
          nextState_s = WAIT;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Nothing is requested or delivered while reset is asserted.
  assign im_req      = reqRaw_s & rst_n;
  assign fetch_stall = ~(advance_s & rst_n);

  // FSM, PC and load-use hold buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      holdPc_r    <= 32'h0000_0000;
      holdInstr_r <= 32'h0000_0000;
    end else begin
      state_r <= nextState_s;
      pc_r    <= nextPc_s;
      if (holdLoad_s) begin
        holdPc_r    <= fetchPc_s;
        holdInstr_r <= fetchInstr_s;
      end else begin
        holdPc_r    <= holdPc_r;
        holdInstr_r <= holdInstr_r;
      end
    end
  end

  if_id_reg u_ifId (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ifidLoad_s),
    .flush     (ifidFlush_s),
    .pcIn      (fetchPc_s),
    .instrIn   (fetchInstr_s),
    .IFID_pc   (IFID_pc),
    .IFID_instr(IFID_instr),
    .IFID_valid(IFID_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one vector per clock cycle,
// plus hand sequences for mid-request reset and PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  BranchCtrl;
  logic [31:0] pc_imm_target, rs1_imm_target;
  logic        PCWrite, IFID_RegWrite, InstrFlush;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_valid;
  logic [31:0] im_rdata;
  logic        fetch_stall;
  logic [31:0] IFID_pc, IFID_instr;
  logic        IFID_valid;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .BranchCtrl(BranchCtrl),
    .pc_imm_target(pc_imm_target), .rs1_imm_target(rs1_imm_target),
    .PCWrite(PCWrite), .IFID_RegWrite(IFID_RegWrite), .InstrFlush(InstrFlush),
    .im_req(im_req), .im_addr(im_addr), .im_valid(im_valid), .im_rdata(im_rdata),
    .fetch_stall(fetch_stall), .IFID_pc(IFID_pc), .IFID_instr(IFID_instr),
    .IFID_valid(IFID_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;   logic [31:0] rdata;
    logic [1:0]  br;    logic [31:0] tImm;  logic [31:0] tRs1;
    logic        pcWr;  logic        ifWr;  logic        fl;
    logic        eReq;  logic [31:0] eAddr; logic        eStall;
    logic [31:0] ePc;   logic [31:0] eInstr; logic       eValid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vld, logic [31:0] rdata, logic [1:0] br,
                              logic [31:0] tImm, logic [31:0] tRs1,
                              logic pcWr, logic ifWr, logic fl,
                              logic eReq, logic [31:0] eAddr, logic eStall,
                              logic [31:0] ePc, logic [31:0] eInstr, logic eValid);
    vec_t v;
    v.vld = vld; v.rdata = rdata; v.br = br; v.tImm = tImm; v.tRs1 = tRs1;
    v.pcWr = pcWr; v.ifWr = ifWr; v.fl = fl;
    v.eReq = eReq; v.eAddr = eAddr; v.eStall = eStall;
    v.ePc = ePc; v.eInstr = eInstr; v.eValid = eValid;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic vld, logic [31:0] rdata, logic [1:0] br,
                       logic [31:0] tImm, logic [31:0] tRs1,
                       logic pcWr, logic ifWr, logic fl);
    im_valid = vld; im_rdata = rdata; BranchCtrl = br;
    pc_imm_target = tImm; rs1_imm_target = tRs1;
    PCWrite = pcWr; IFID_RegWrite = ifWr; InstrFlush = fl;
  endtask

  // Compares outputs against a vector; IFID_pc is only meaningful for valid slots.
  task automatic checkVec(int idx, vec_t v);
    string s;
    s = $sformatf("v%0d", idx);
    chk({s, ".im_req"}, {31'd0, im_req}, {31'd0, v.eReq});
    if (v.eReq) chk({s, ".im_addr"}, im_addr, v.eAddr);
    chk({s, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, v.eStall});
    chk({s, ".IFID_valid"}, {31'd0, IFID_valid}, {31'd0, v.eValid});
    chk({s, ".IFID_instr"}, IFID_instr, v.eInstr);
    if (v.eValid) chk({s, ".IFID_pc"}, IFID_pc, v.ePc);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    //          vld  rdata          br     tImm          tRs1          pcW  ifW  fl    req  addr          stall ePc            eInstr         eV
    vecs.push_back(mk(1'b0, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0000,1'b1, 32'h0,         NOP,           1'b0)); // c0 IDLE
    vecs.push_back(mk(1'b1, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0004,1'b0, 32'h0,         NOP,           1'b0));
    vecs.push_back(mk(1'b1, 32'h4,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0008,1'b0, 32'h0,         32'h0,         1'b1));
    vecs.push_back(mk(1'b1, 32'h8,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_000C,1'b0, 32'h4,         32'h4,         1'b1));
    vecs.push_back(mk(1'b0, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b0,32'h0,        1'b1, 32'h8,         32'h8,         1'b1)); // c4 latency
    vecs.push_back(mk(1'b0, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b0,32'h0,        1'b1, 32'h8,         32'h8,         1'b1));
    vecs.push_back(mk(1'b0, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b0,32'h0,        1'b1, 32'h8,         32'h8,         1'b1));
    vecs.push_back(mk(1'b1, 32'hC,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0010,1'b0, 32'h8,         32'h8,         1'b1));
    vecs.push_back(mk(1'b1, 32'h10,       2'b00, 32'h0,        32'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0,        1'b0, 32'hC,         32'hC,         1'b1)); // c8 load-use
    vecs.push_back(mk(1'b1, 32'hBAD0_BAD0,2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0014,1'b0, 32'hC,         32'hC,         1'b1)); // HOLD ignores im_valid
    vecs.push_back(mk(1'b1, 32'h14,       2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0018,1'b0, 32'h10,        32'h10,        1'b1));
    vecs.push_back(mk(1'b1, 32'h18,       2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_001C,1'b0, 32'h14,        32'h14,        1'b1));
    vecs.push_back(mk(1'b1, 32'h1C,       2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0020,1'b0, 32'h18,        32'h18,        1'b1));
    vecs.push_back(mk(1'b1, 32'h20,       2'b01, 32'h100,      32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0100,1'b0, 32'h1C,        32'h1C,        1'b1)); // c13 PCIMM
    vecs.push_back(mk(1'b1, 32'h100,      2'b10, 32'h0,        32'h203,      1'b1,1'b1,1'b0, 1'b1,32'h0000_0202,1'b0, 32'h0,         NOP,           1'b0)); // IMMRS1
    vecs.push_back(mk(1'b1, 32'h202,      2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0206,1'b0, 32'h0,         NOP,           1'b0));
    vecs.push_back(mk(1'b1, 32'h206,      2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b1, 1'b1,32'h0000_020A,1'b0, 32'h202,       32'h202,       1'b1)); // InstrFlush
    vecs.push_back(mk(1'b1, 32'h20A,      2'b00, 32'h0,        32'h0,        1'b0,1'b0,1'b0, 1'b0,32'h0,        1'b0, 32'h0,         NOP,           1'b0)); // -> HOLD
    vecs.push_back(mk(1'b0, 32'h0,        2'b01, 32'h300,      32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0300,1'b0, 32'h0,         NOP,           1'b0)); // redirect in HOLD
    vecs.push_back(mk(1'b0, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b0,32'h0,        1'b1, 32'h0,         NOP,           1'b0));
    vecs.push_back(mk(1'b1, 32'h300,      2'b11, 32'h500,      32'h501,      1'b1,1'b1,1'b0, 1'b1,32'h0000_0304,1'b0, 32'h0,         NOP,           1'b0)); // 2'b11 = PC4
    vecs.push_back(mk(1'b1, 32'h304,      2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b1,32'h0000_0308,1'b0, 32'h300,       32'h300,       1'b1));
    vecs.push_back(mk(1'b0, 32'h0,        2'b00, 32'h0,        32'h0,        1'b1,1'b1,1'b0, 1'b0,32'h0,        1'b1, 32'h304,       32'h304,       1'b1)); // 0x308 outstanding

    repeat (2) @(posedge clk);
    #1;
    chk("rst.im_req", {31'd0, im_req}, 32'd0);
    chk("rst.fetch_stall", {31'd0, fetch_stall}, 32'd1);
    chk("rst.IFID_pc", IFID_pc, 32'h0);
    chk("rst.IFID_instr", IFID_instr, NOP);
    chk("rst.IFID_valid", {31'd0, IFID_valid}, 32'd0);

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.vld, v.rdata, v.br, v.tImm, v.tRs1, v.pcWr, v.ifWr, v.fl);
      #3;
      checkVec(i, v);
      @(posedge clk);
      #1;
    end

    // Reset while 0x308 is outstanding; the late response must be ignored.
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("mid.rst_req", {31'd0, im_req}, 32'd0);
    chk("mid.rst_stall", {31'd0, fetch_stall}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("mid.req", {31'd0, im_req}, 32'd1);
    chk("mid.addr", im_addr, 32'h0000_0000);
    chk("mid.stall", {31'd0, fetch_stall}, 32'd1);
    chk("mid.ifid_pc", IFID_pc, 32'h0);
    chk("mid.ifid_valid", {31'd0, IFID_valid}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("mid.wait_stall", {31'd0, fetch_stall}, 32'd1);
    chk("mid.wait_req", {31'd0, im_req}, 32'd0);
    chk("mid.ifid_instr", IFID_instr, NOP);

    // Redirect to the top of the address space, then sequential wrap to 0.
    @(posedge clk); #1;
    drive(1'b1, 32'h0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("wrap.redir_addr", im_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    drive(1'b1, 32'h1234_5678, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("wrap.req", {31'd0, im_req}, 32'd1);
    chk("wrap.addr", im_addr, 32'h0000_0000);
    @(posedge clk); #1;
    drive(1'b1, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    #3;
    chk("wrap.ifid_pc", IFID_pc, 32'hFFFF_FFFC);
    chk("wrap.ifid_instr", IFID_instr, 32'h1234_5678);
    chk("wrap.ifid_valid", {31'd0, IFID_valid}, 32'd1);
    chk("wrap.next_addr", im_addr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
